// File: rtl/track_lock_ctrl.sv
// track_lock_ctrl
//   Frame-rate tracking controller for the red-object detector. At each
//   frame boundary (rising edge of v_sync) it samples the detector's
//   per-frame result, qualifies it, steps a SEARCH/ACQUIRE/LOCK/COAST state
//   machine, and maintains a smoothed target position. It also drives the
//   detector's filter_on input, changing it only at frame boundaries.
//
// Ports
//   VGA_clock    in   pixel clock (only clock)
//   reset        in   synchronous, active-high reset
//   v_sync       in   frame sync, low during vertical blank
//   horz_line    in   [8:0] object row from the detector
//   vert_line    in   [9:0] object centre column from the detector
//   streak_len   in   [9:0] longest red streak in the frame
//   filter_req   in   user filter enable
//   auto_filter  in   force filter on while not tracking
//   filter_on    out  filter enable to the detector
//   target_x     out  [9:0] smoothed column
//   target_y     out  [8:0] smoothed row
//   target_valid out  one-cycle pulse on a locked position update
//   lock         out  state is LOCK
//   lost         out  state is SEARCH
//   trk_state    out  [1:0] SEARCH=0 ACQUIRE=1 LOCK=2 COAST=3
module track_lock_ctrl #(
  parameter int MIN_LEN      = 8,
  parameter int MAX_JUMP     = 32,
  parameter int ACQ_FRAMES   = 3,
  parameter int COAST_FRAMES = 4,
  parameter int SMOOTH_SHIFT = 1
) (
  input  logic       VGA_clock,
  input  logic       reset,
  input  logic       v_sync,
  input  logic [8:0] horz_line,
  input  logic [9:0] vert_line,
  input  logic [9:0] streak_len,
  input  logic       filter_req,
  input  logic       auto_filter,
  output logic       filter_on,
  output logic [9:0] target_x,
  output logic [8:0] target_y,
  output logic       target_valid,
  output logic       lock,
  output logic       lost,
  output logic [1:0] trk_state
);

  localparam int CNT_MAX = (ACQ_FRAMES > COAST_FRAMES) ? ACQ_FRAMES : COAST_FRAMES;
  localparam int CNT_W_RAW = $clog2(CNT_MAX + 1);
  localparam int CNT_W = (CNT_W_RAW < 3) ? 3 : CNT_W_RAW;

  localparam logic [10:0]      MIN_LEN_L  = 11'(MIN_LEN);
  localparam logic [10:0]      MAX_JUMP_L = 11'(MAX_JUMP);
  localparam logic [CNT_W-1:0] ACQ_L      = CNT_W'(ACQ_FRAMES);
  localparam logic [CNT_W-1:0] COAST_L    = CNT_W'(COAST_FRAMES);
  localparam logic [9:0]       TX_RST     = 10'd320;
  localparam logic [8:0]       TY_RST     = 9'd240;

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCK    = 2'd2,
    S_COAST   = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_vs_d;
  logic             r_skip;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic                w_boundary;
  logic                w_hit;
  logic                w_consistent;
  logic signed [10:0]  w_dx_s;
  logic signed [10:0]  w_dy_s;
  logic [10:0]         w_dx_abs;
  logic [10:0]         w_dy_abs;
  logic [9:0]          w_sx;
  logic [8:0]          w_sy;
  logic [CNT_W-1:0]    w_hit_inc;
  logic [CNT_W-1:0]    w_miss_inc;

  state_t           w_state_nx;
  logic [9:0]       w_tx_nx;
  logic [8:0]       w_ty_nx;
  logic [CNT_W-1:0] w_hit_nx;
  logic [CNT_W-1:0] w_miss_nx;
  logic             w_tv_nx;
  logic             w_filter_nx;

  assign w_boundary = v_sync & ~r_vs_d;

  // Measurement qualification against the current target.
  assign w_hit    = ({1'b0, streak_len} >= MIN_LEN_L);
  assign w_dx_s   = $signed({1'b0, vert_line}) - $signed({1'b0, target_x});
  assign w_dy_s   = $signed({2'b00, horz_line}) - $signed({2'b00, target_y});
  assign w_dx_abs = w_dx_s[10] ? 11'(-w_dx_s) : 11'(w_dx_s);
  assign w_dy_abs = w_dy_s[10] ? 11'(-w_dy_s) : 11'(w_dy_s);
  assign w_consistent = w_hit && (w_dx_abs <= MAX_JUMP_L) && (w_dy_abs <= MAX_JUMP_L);

  // Exponential smoothing; the arithmetic shift keeps the result between
  // old and meas, so truncation to the output width is lossless.
  assign w_sx = 10'($signed({1'b0, target_x}) + (w_dx_s >>> SMOOTH_SHIFT));
  assign w_sy = 9'($signed({2'b00, target_y}) + (w_dy_s >>> SMOOTH_SHIFT));

  // Saturating increments so a counter can never wrap back to zero.
  assign w_hit_inc  = (r_hit_cnt  == '1) ? r_hit_cnt  : r_hit_cnt  + 1'b1;
  assign w_miss_inc = (r_miss_cnt == '1) ? r_miss_cnt : r_miss_cnt + 1'b1;

  always_comb begin
    w_state_nx = r_state;
    w_tx_nx    = target_x;
    w_ty_nx    = target_y;
    w_hit_nx   = r_hit_cnt;
    w_miss_nx  = r_miss_cnt;
    w_tv_nx    = 1'b0;
    case (r_state)
      S_SEARCH: begin
        if (w_hit) begin
          w_tx_nx    = vert_line;
          w_ty_nx    = horz_line;
          w_hit_nx   = CNT_W'(1);
          w_state_nx = S_ACQUIRE;
        end
      end
      S_ACQUIRE: begin
        if (w_consistent) begin
          w_tx_nx = w_sx;
          w_ty_nx = w_sy;
          if (w_hit_inc == ACQ_L) begin
            w_state_nx = S_LOCK;
            w_hit_nx   = '0;
          end else begin
            w_hit_nx = w_hit_inc;
          end
        end else begin
          w_state_nx = S_SEARCH;
          w_tx_nx    = TX_RST;
          w_ty_nx    = TY_RST;
          w_hit_nx   = '0;
        end
      end
      S_LOCK: begin
        if (w_consistent) begin
          w_tx_nx   = w_sx;
          w_ty_nx   = w_sy;
          w_miss_nx = '0;
          w_tv_nx   = 1'b1;
        end else begin
          w_state_nx = S_COAST;
          w_miss_nx  = CNT_W'(1);
        end
      end
      S_COAST: begin
        if (w_consistent) begin
          w_tx_nx    = w_sx;
          w_ty_nx    = w_sy;
          w_state_nx = S_LOCK;
          w_miss_nx  = '0;
          w_tv_nx    = 1'b1;
        end else if (w_miss_inc == COAST_L) begin
          w_state_nx = S_SEARCH;
          w_tx_nx    = TX_RST;
          w_ty_nx    = TY_RST;
          w_miss_nx  = '0;
        end else begin
          w_miss_nx = w_miss_inc;
        end
      end
      default: ;
    endcase
    // Filter mode follows the state being entered, not the one being left.
    w_filter_nx = (auto_filter && (w_state_nx == S_SEARCH || w_state_nx == S_ACQUIRE))
                  ? 1'b1 : filter_req;
  end

  always_ff @(posedge VGA_clock) begin
    if (reset) begin
      r_state      <= S_SEARCH;
      target_x     <= TX_RST;
      target_y     <= TY_RST;
      target_valid <= 1'b0;
      filter_on    <= 1'b1;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_vs_d       <= 1'b1;
      r_skip       <= 1'b1;
    end else begin
      r_vs_d       <= v_sync;
      target_valid <= 1'b0;
      if (w_boundary) begin
        // The first boundary after reset closes a partial frame whose
        // detector result is meaningless, so it only arms normal operation.
        if (r_skip) begin
          r_skip <= 1'b0;
        end else begin
          r_state      <= w_state_nx;
          target_x     <= w_tx_nx;
          target_y     <= w_ty_nx;
          r_hit_cnt    <= w_hit_nx;
          r_miss_cnt   <= w_miss_nx;
          target_valid <= w_tv_nx;
          filter_on    <= w_filter_nx;
        end
      end
    end
  end

  assign trk_state = r_state;
  assign lock      = (r_state == S_LOCK);
  assign lost      = (r_state == S_SEARCH);

endmodule

// File: tb/tb_track_lock_ctrl.sv
module tb_track_lock_ctrl;

  localparam int MIN_LEN      = 8;
  localparam int MAX_JUMP     = 32;
  localparam int ACQ_FRAMES   = 3;
  localparam int COAST_FRAMES = 4;
  localparam int SMOOTH_SHIFT = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       v_sync;
  logic [8:0] horz_line;
  logic [9:0] vert_line;
  logic [9:0] streak_len;
  logic       filter_req;
  logic       auto_filter;
  logic       filter_on;
  logic [9:0] target_x;
  logic [8:0] target_y;
  logic       target_valid;
  logic       lock;
  logic       lost;
  logic [1:0] trk_state;

  track_lock_ctrl #(
    .MIN_LEN(MIN_LEN), .MAX_JUMP(MAX_JUMP), .ACQ_FRAMES(ACQ_FRAMES),
    .COAST_FRAMES(COAST_FRAMES), .SMOOTH_SHIFT(SMOOTH_SHIFT)
  ) dut (
    .VGA_clock(clk), .reset(reset), .v_sync(v_sync),
    .horz_line(horz_line), .vert_line(vert_line), .streak_len(streak_len),
    .filter_req(filter_req), .auto_filter(auto_filter), .filter_on(filter_on),
    .target_x(target_x), .target_y(target_y), .target_valid(target_valid),
    .lock(lock), .lost(lost), .trk_state(trk_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integer tracker state (0=SEARCH 1=ACQ 2=LOCK 3=COAST)
  int m_state, m_tx, m_ty, m_hc, m_mc, m_fo, m_tv;
  bit m_skip;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // old + floor((meas-old) / 2^SMOOTH_SHIFT)
  function automatic int smooth(input int old_v, input int meas);
    int d, p, q;
    d = meas - old_v;
    p = 1 << SMOOTH_SHIFT;
    q = d / p;
    if ((d % p != 0) && d < 0) q = q - 1;
    return old_v + q;
  endfunction

  task automatic model_reset();
    m_state = 0; m_tx = 320; m_ty = 240; m_hc = 0; m_mc = 0;
    m_fo = 1; m_tv = 0; m_skip = 1'b1;
  endtask

  task automatic model_step(input int x, input int y, input int len,
                            input int freq, input int aut);
    bit hit, cons;
    m_tv = 0;
    if (m_skip) begin
      m_skip = 1'b0;
      return;
    end
    hit  = (len >= MIN_LEN);
    cons = hit && iabs(x - m_tx) <= MAX_JUMP && iabs(y - m_ty) <= MAX_JUMP;
    case (m_state)
      0: if (hit) begin m_tx = x; m_ty = y; m_hc = 1; m_state = 1; end
      1: if (cons) begin
           m_tx = smooth(m_tx, x); m_ty = smooth(m_ty, y); m_hc++;
           if (m_hc == ACQ_FRAMES) begin m_state = 2; m_hc = 0; end
         end else begin
           m_state = 0; m_tx = 320; m_ty = 240; m_hc = 0;
         end
      2: if (cons) begin
           m_tx = smooth(m_tx, x); m_ty = smooth(m_ty, y); m_mc = 0; m_tv = 1;
         end else begin
           m_state = 3; m_mc = 1;
         end
      default: if (cons) begin
           m_tx = smooth(m_tx, x); m_ty = smooth(m_ty, y);
           m_state = 2; m_mc = 0; m_tv = 1;
         end else begin
           m_mc++;
           if (m_mc == COAST_FRAMES) begin
             m_state = 0; m_tx = 320; m_ty = 240; m_mc = 0;
           end
         end
    endcase
    m_fo = (aut != 0 && m_state <= 1) ? 1 : freq;
  endtask

  task automatic check_all();
    check("trk_state", int'(trk_state), m_state);
    check("target_x", int'(target_x), m_tx);
    check("target_y", int'(target_y), m_ty);
    check("target_valid", int'(target_valid), m_tv);
    check("lock", int'(lock), (m_state == 2) ? 1 : 0);
    check("lost", int'(lost), (m_state == 0) ? 1 : 0);
    check("filter_on", int'(filter_on), m_fo);
  endtask

  // Inputs that must be ignored away from the boundary cycle.
  task automatic scramble(input bit inc_filter);
    horz_line  = 9'($urandom_range(479));
    vert_line  = 10'($urandom_range(639));
    streak_len = 10'($urandom_range(1023));
    if (inc_filter) begin
      filter_req  = 1'($urandom);
      auto_filter = 1'($urandom);
    end
  endtask

  // One frame: blank, then rising v_sync carrying the real measurement.
  task automatic do_frame(input int x, input int y, input int len, input int freq,
                          input int aut, input int n_blank, input int n_active);
    @(negedge clk);
    v_sync = 1'b0;
    scramble(1'b1);
    repeat (n_blank - 1) begin
      @(negedge clk);
      scramble(1'b1);
    end
    check_all();                      // long blank changes nothing
    v_sync      = 1'b1;
    horz_line   = 9'(y);
    vert_line   = 10'(x);
    streak_len  = 10'(len);
    filter_req  = 1'(freq);
    auto_filter = 1'(aut);
    model_step(x, y, len, freq, aut);
    @(negedge clk);                   // edge ending the boundary cycle has passed
    check_all();
    scramble(1'b1);                   // mid-frame filter toggles must not matter
    m_tv = 0;
    @(negedge clk);
    check_all();
    repeat (n_active - 2) begin
      scramble(1'b1);
      @(negedge clk);
    end
  endtask

  task automatic frame(input int x, input int y, input int len);
    do_frame(x, y, len, 0, 1, 3, 3);
  endtask

  task automatic check_reset_values();
    check("rst_state", int'(trk_state), 0);
    check("rst_tx", int'(target_x), 320);
    check("rst_ty", int'(target_y), 240);
    check("rst_tv", int'(target_valid), 0);
    check("rst_filter", int'(filter_on), 1);
    check("rst_lock", int'(lock), 0);
    check("rst_lost", int'(lost), 1);
  endtask

  initial begin
    int x, y, len;
    reset = 1'b1; v_sync = 1'b1;
    horz_line = '0; vert_line = '0; streak_len = '0;
    filter_req = 1'b0; auto_filter = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values();
    model_reset();
    reset = 1'b0;

    // Partial first frame is ignored, then acquisition to lock.
    frame(100, 50, 20);
    $display("partial frame: state=%0d", trk_state);
    frame(100, 50, 20);
    $display("hit1: state=%0d tgt=(%0d,%0d)", trk_state, target_x, target_y);
    frame(100, 50, 20);
    $display("hit2: state=%0d", trk_state);
    frame(100, 50, 20);
    $display("hit3: state=%0d filter_on=%0d", trk_state, filter_on);
    frame(100, 50, 20);
    $display("hit4: state=%0d", trk_state);
    frame(110, 60, 20);
    $display("smooth: tgt=(%0d,%0d)", target_x, target_y);
    check("smooth_x", int'(target_x), 105);
    check("smooth_y", int'(target_y), 55);
    frame(60, 50, 20);
    $display("jump: state=%0d tgt=(%0d,%0d)", trk_state, target_x, target_y);
    check("coast_state", int'(trk_state), 3);
    for (int i = 0; i < 4; i++) begin
      frame(105, 55, 2);
      $display("miss%0d: state=%0d", i + 1, trk_state);
    end
    check("lost_after_coast", int'(lost), 1);

    // Re-acquire, coast two misses, recover.
    for (int i = 0; i < 4; i++) frame(200, 300, 15);
    frame(200, 300, 3);
    frame(200, 300, 3);
    frame(210, 290, 15);
    $display("recover: state=%0d tv_model=%0d tgt=(%0d,%0d)", trk_state, m_tv, target_x, target_y);
    check("recover_state", int'(trk_state), 2);

    // Reset for one cycle while locked.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values();
    $display("mid-lock reset: state=%0d", trk_state);
    model_reset();
    reset = 1'b0;

    // Randomized frames against the model.
    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(3) == 0) begin
        x = $urandom_range(639);
        y = $urandom_range(479);
      end else begin
        x = m_tx + $urandom_range(80) - 40;
        y = m_ty + $urandom_range(80) - 40;
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        if (y < 0) y = 0;
        if (y > 479) y = 479;
      end
      len = ($urandom_range(3) == 0) ? $urandom_range(MIN_LEN - 1) : $urandom_range(40, MIN_LEN);
      do_frame(x, y, len, $urandom_range(1), $urandom_range(1),
               $urandom_range(6, 2), $urandom_range(6, 2));
      $display("rand frame %0d: meas=(%0d,%0d,%0d) state=%0d tgt=(%0d,%0d)",
               f, x, y, len, trk_state, target_x, target_y);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
